// File: rtl/lane_ctrl_pkg.sv
// Shared encodings and constants for the per-lane RX bring-up sequencer.
// The state encodings are also the values driven on STATE_OUT.
package lane_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StDecRst   = 3'd1,
    StWaitLock = 3'd2,
    StMfHunt   = 3'd3,
    StMfCheck  = 3'd4,
    StUp       = 3'd5,
    StRetry    = 3'd6,
    StFail     = 3'd7
  } lane_state_e;

  localparam logic [63:0] SYNC_WORD      = 64'h78F6_78F6_78F6_78F6;
  localparam logic [1:0]  CTRL_HEADER    = 2'b10;
  localparam int unsigned DEC_RST_CYCLES = 4;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned RETRY_W        = 4;

  function automatic logic is_sync(input logic [1:0] hdr, input logic [63:0] data);
    return (hdr == CTRL_HEADER) && (data == SYNC_WORD);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lane_timer.sv
// Down-counter with load, clear and expire. It saturates at zero; o_expired is
// high while the count reads zero.
module lane_timer #(
  parameter int unsigned     Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [Width-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= ResetVal;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/lane_bringup_ctrl.sv
// Per-lane RX bring-up sequencer: GT settle, decoder reset, word lock, then
// Interlaken metaframe sync hunt/track with bounded GT-reset retries.
module lane_bringup_ctrl
  import lane_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned MF_LEN       = 2048,
  parameter int unsigned HUNT_TIMEOUT = 8192,
  parameter int unsigned MF_GOOD      = 4,
  parameter int unsigned MF_BAD       = 4,
  parameter int unsigned SETTLE       = 16,
  parameter int unsigned MAX_RETRIES  = 7
) (
  input  logic                USER_CLK,
  input  logic                SYSTEM_RESET_N,
  input  logic                GT_RESET_DONE,
  output logic                GT_RESET_REQ,
  output logic                DEC_PASSTHROUGH,
  output logic                DEC_RESET,
  input  logic                DEC_LOCKED,
  input  logic [63:0]         DEC_DATA,
  input  logic [1:0]          DEC_HEADER,
  output logic                LANE_UP,
  output logic                ERR_FATAL,
  output logic [RETRY_W-1:0]  RETRY_CNT,
  output logic [2:0]          STATE_OUT
);

  localparam int unsigned TmrMax = max2(max2(LOCK_TIMEOUT, HUNT_TIMEOUT),
                                        max2(SETTLE, DEC_RST_CYCLES));
  localparam int unsigned TmrW   = $clog2(TmrMax);
  localparam int unsigned SlotW  = (MF_LEN > 2) ? $clog2(MF_LEN) : 1;

  localparam logic [CNT_W-1:0]   GoodTgt  = CNT_W'(MF_GOOD);
  localparam logic [CNT_W-1:0]   BadTgt   = CNT_W'(MF_BAD);
  localparam logic [RETRY_W-1:0] MaxRetry = RETRY_W'(MAX_RETRIES);

  lane_state_e        r_state, w_state_d;
  logic [CNT_W-1:0]   r_good, w_good_d, w_good_inc;
  logic [CNT_W-1:0]   r_bad, w_bad_d, w_bad_inc;
  logic [RETRY_W-1:0] r_retry, w_retry_d;

  logic               w_sync_hit;
  logic               w_gt_lost;
  logic               w_tmr_load, w_tmr_exp;
  logic [TmrW-1:0]    w_tmr_val;
  logic               w_slot_clr, w_slot_load, w_slot_exp;

  logic               r_pass, r_dec_rst, r_req, r_up, r_fatal;
  logic               w_pass_d, w_dec_rst_d, w_req_d, w_up_d, w_fatal_d;

  assign w_sync_hit = is_sync(DEC_HEADER, DEC_DATA);
  assign w_good_inc = (&r_good) ? r_good : r_good + 1'b1;
  assign w_bad_inc  = (&r_bad) ? r_bad : r_bad + 1'b1;
  assign w_gt_lost  = !GT_RESET_DONE &&
                      (r_state inside {StDecRst, StWaitLock, StMfHunt, StMfCheck, StUp});

  // Shared timer: settle count in IDLE, reset hold, lock and hunt timeouts.
  always_comb begin
    w_tmr_load = (w_state_d != r_state) || ((r_state == StIdle) && !GT_RESET_DONE);
    case (w_state_d)
      StDecRst:   w_tmr_val = TmrW'(DEC_RST_CYCLES - 1);
      StWaitLock: w_tmr_val = TmrW'(LOCK_TIMEOUT - 1);
      StMfHunt:   w_tmr_val = TmrW'(HUNT_TIMEOUT - 1);
      default:    w_tmr_val = TmrW'(SETTLE - 1);
    endcase
  end

  lane_timer #(
    .Width    (TmrW),
    .ResetVal (TmrW'(SETTLE - 1))
  ) u_state_timer (
    .i_clk      (USER_CLK),
    .i_rst_n    (SYSTEM_RESET_N),
    .i_clr      (1'b0),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (1'b1),
    .o_expired  (w_tmr_exp)
  );

  // Held in reload while hunting so it is aligned to the hunt's sync word.
  assign w_slot_clr  = !(r_state inside {StMfHunt, StMfCheck, StUp});
  assign w_slot_load = (r_state == StMfHunt) || w_slot_exp;

  lane_timer #(
    .Width    (SlotW),
    .ResetVal ('0)
  ) u_slot_timer (
    .i_clk      (USER_CLK),
    .i_rst_n    (SYSTEM_RESET_N),
    .i_clr      (w_slot_clr),
    .i_load     (w_slot_load),
    .i_load_val (SlotW'(MF_LEN - 1)),
    .i_en       (1'b1),
    .o_expired  (w_slot_exp)
  );

  always_comb begin
    w_state_d = r_state;
    w_good_d  = r_good;
    w_bad_d   = r_bad;
    w_retry_d = r_retry;
    if (w_gt_lost) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (GT_RESET_DONE && w_tmr_exp) w_state_d = StDecRst;
        end
        StDecRst: begin
          if (w_tmr_exp) w_state_d = StWaitLock;
        end
        StWaitLock: begin
          if (DEC_LOCKED) w_state_d = StMfHunt;
          else if (w_tmr_exp) w_state_d = StRetry;
        end
        StMfHunt: begin
          if (!DEC_LOCKED) begin
            w_state_d = StRetry;
          end else if (w_sync_hit) begin
            w_state_d = StMfCheck;
            w_good_d  = CNT_W'(1);
          end else if (w_tmr_exp) begin
            w_state_d = StRetry;
          end
        end
        StMfCheck: begin
          if (!DEC_LOCKED) begin
            w_state_d = StRetry;
          end else if (w_slot_exp) begin
            if (w_sync_hit) begin
              w_good_d = w_good_inc;
              if (w_good_inc == GoodTgt) begin
                w_state_d = StUp;
                w_bad_d   = '0;
                w_retry_d = '0;
              end
            end else begin
              w_state_d = StMfHunt;
              w_good_d  = '0;
            end
          end
        end
        StUp: begin
          if (!DEC_LOCKED) begin
            w_state_d = StRetry;
          end else if (w_slot_exp) begin
            if (w_sync_hit) begin
              w_bad_d = '0;
            end else begin
              w_bad_d = w_bad_inc;
              if (w_bad_inc == BadTgt) w_state_d = StRetry;
            end
          end
        end
        StRetry: begin
          if (r_retry == MaxRetry) begin
            w_state_d = StFail;
          end else begin
            w_state_d = StIdle;
            w_retry_d = (&r_retry) ? r_retry : r_retry + 1'b1;
          end
        end
        StFail: begin
          w_state_d = StFail;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change with STATE_OUT.
  always_comb begin
    w_pass_d    = w_state_d inside {StIdle, StRetry, StFail};
    w_dec_rst_d = w_pass_d || (w_state_d == StDecRst);
    w_req_d     = (w_state_d == StRetry) && (w_retry_d != MaxRetry);
    w_up_d      = (w_state_d == StUp);
    w_fatal_d   = (w_state_d == StFail);
  end

  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      r_state   <= StIdle;
      r_good    <= '0;
      r_bad     <= '0;
      r_retry   <= '0;
      r_pass    <= 1'b1;
      r_dec_rst <= 1'b1;
      r_req     <= 1'b0;
      r_up      <= 1'b0;
      r_fatal   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_good    <= w_good_d;
      r_bad     <= w_bad_d;
      r_retry   <= w_retry_d;
      r_pass    <= w_pass_d;
      r_dec_rst <= w_dec_rst_d;
      r_req     <= w_req_d;
      r_up      <= w_up_d;
      r_fatal   <= w_fatal_d;
    end
  end

  assign GT_RESET_REQ    = r_req;
  assign DEC_PASSTHROUGH = r_pass;
  assign DEC_RESET       = r_dec_rst;
  assign LANE_UP         = r_up;
  assign ERR_FATAL       = r_fatal;
  assign RETRY_CNT       = r_retry;
  assign STATE_OUT       = r_state;

endmodule

// File: tb/tb_lane_bringup_ctrl.sv
// Directed bench for lane_bringup_ctrl: settle, lane up, slot loss, lock loss,
// GT loss and the retry-exhaustion path with small timeout parameters.
module tb_lane_bringup_ctrl;

  localparam logic [63:0] SyncWord = 64'h78F6_78F6_78F6_78F6;
  localparam logic [63:0] IdleWord = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gt_done;
  logic        gt_req;
  logic        dec_pass;
  logic        dec_rst;
  logic        dec_locked;
  logic [63:0] dec_data;
  logic [1:0]  dec_hdr;
  logic        lane_up;
  logic        err_fatal;
  logic [3:0]  retry_cnt;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hi, n_req, n_retry, n_wait, n_iter;

  always #5 clk = ~clk;

  lane_bringup_ctrl #(
    .LOCK_TIMEOUT (64),
    .MF_LEN       (16),
    .HUNT_TIMEOUT (128),
    .MF_GOOD      (4),
    .MF_BAD       (4),
    .SETTLE       (16),
    .MAX_RETRIES  (7)
  ) dut (
    .USER_CLK        (clk),
    .SYSTEM_RESET_N  (rst_n),
    .GT_RESET_DONE   (gt_done),
    .GT_RESET_REQ    (gt_req),
    .DEC_PASSTHROUGH (dec_pass),
    .DEC_RESET       (dec_rst),
    .DEC_LOCKED      (dec_locked),
    .DEC_DATA        (dec_data),
    .DEC_HEADER      (dec_hdr),
    .LANE_UP         (lane_up),
    .ERR_FATAL       (err_fatal),
    .RETRY_CNT       (retry_cnt),
    .STATE_OUT       (state)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input bit sync);
    dec_hdr  = sync ? 2'b10 : 2'b01;
    dec_data = sync ? SyncWord : IdleWord;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int bound, input string tag);
    int i;
    i = 0;
    while ((state != tgt) && (i < bound)) begin
      tick();
      i++;
    end
    check_val(tag, 32'(state), 32'(tgt));
  endtask

  // One metaframe: 15 off-slot words (optional stray sync) then the slot word.
  task automatic mf_period(input bit hit, input bit stray);
    for (int i = 0; i < 15; i++) begin
      set_word(stray && (i == 7));
      tick();
    end
    set_word(hit);
    tick();
    set_word(1'b0);
  endtask

  task automatic bring_up();
    dec_locked = 1'b0;
    set_word(1'b0);
    wait_state(3'd2, 200, "reach_wait_lock");
    dec_locked = 1'b1;
    tick();
    check_val("locked_to_hunt", 32'(state), 32'd3);
    set_word(1'b1);
    tick();
    set_word(1'b0);
    check_val("hunt_hit_check", 32'(state), 32'd4);
    for (int k = 0; k < 3; k++) begin
      check_val("check_not_up", 32'(lane_up), 32'd0);
      mf_period(1'b1, 1'b0);
    end
    check_val("up_state", 32'(state), 32'd5);
    check_val("up_lane_up", 32'(lane_up), 32'd1);
    check_val("up_retry_clr", 32'(retry_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    gt_done    = 1'b0;
    dec_locked = 1'b0;
    set_word(1'b0);
    repeat (3) tick();

    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_pass", 32'(dec_pass), 32'd1);
    check_val("rst_decrst", 32'(dec_rst), 32'd1);
    check_val("rst_req", 32'(gt_req), 32'd0);
    check_val("rst_up", 32'(lane_up), 32'd0);
    check_val("rst_fatal", 32'(err_fatal), 32'd0);
    check_val("rst_retry", 32'(retry_cnt), 32'd0);

    // Settle: 16 consecutive high cycles move IDLE to DEC_RST.
    rst_n   = 1'b1;
    gt_done = 1'b1;
    repeat (15) tick();
    check_val("settle15_idle", 32'(state), 32'd0);
    tick();
    check_val("settle16_decrst", 32'(state), 32'd1);
    check_val("decrst_pass", 32'(dec_pass), 32'd0);
    n_hi = (dec_rst && (state == 3'd1)) ? 1 : 0;
    repeat (4) begin
      tick();
      if (dec_rst && (state == 3'd1)) n_hi++;
    end
    check_val("decrst_cycles", 32'(n_hi), 32'd4);
    check_val("wait_lock_state", 32'(state), 32'd2);
    check_val("wait_lock_decrst", 32'(dec_rst), 32'd0);

    // Lane up on the 4th sync word, then a stray off-slot sync is ignored.
    bring_up();
    mf_period(1'b1, 1'b1);
    check_val("up_stray_hold", 32'(state), 32'd5);

    // Four missed slots drop the lane.
    for (int k = 0; k < 3; k++) begin
      mf_period(1'b0, 1'b0);
      check_val("up_miss_hold", 32'(state), 32'd5);
    end
    mf_period(1'b0, 1'b0);
    check_val("miss4_retry", 32'(state), 32'd6);
    check_val("miss4_req", 32'(gt_req), 32'd1);
    check_val("miss4_lane_down", 32'(lane_up), 32'd0);
    check_val("miss4_pass", 32'(dec_pass), 32'd1);
    tick();
    check_val("retry_to_idle", 32'(state), 32'd0);
    check_val("retry_req_end", 32'(gt_req), 32'd0);
    check_val("retry_cnt1", 32'(retry_cnt), 32'd1);

    // Lock loss on a slot hit wins over the hit.
    bring_up();
    repeat (15) tick();
    set_word(1'b1);
    dec_locked = 1'b0;
    tick();
    set_word(1'b0);
    check_val("lockloss_retry", 32'(state), 32'd6);
    check_val("lockloss_lane_down", 32'(lane_up), 32'd0);
    check_val("lockloss_req", 32'(gt_req), 32'd1);
    tick();
    check_val("lockloss_cnt", 32'(retry_cnt), 32'd1);

    // GT loss in MF_CHECK: straight to IDLE with no retry counted.
    wait_state(3'd2, 200, "reach_wait_lock2");
    dec_locked = 1'b1;
    tick();
    dec_hdr  = 2'b01;
    dec_data = SyncWord;
    tick();
    check_val("bad_hdr_no_hit", 32'(state), 32'd3);
    set_word(1'b1);
    tick();
    set_word(1'b0);
    check_val("gtloss_in_check", 32'(state), 32'd4);
    gt_done = 1'b0;
    tick();
    check_val("gtloss_idle", 32'(state), 32'd0);
    check_val("gtloss_no_req", 32'(gt_req), 32'd0);
    check_val("gtloss_cnt", 32'(retry_cnt), 32'd1);
    check_val("gtloss_decrst", 32'(dec_rst), 32'd1);
    repeat (20) tick();
    check_val("gt_low_idle_hold", 32'(state), 32'd0);

    // Lock never arrives: 8 timeouts of 64 cycles, then FAIL.
    gt_done    = 1'b1;
    dec_locked = 1'b0;
    rst_n      = 1'b0;
    #1;
    check_val("midrst_cnt", 32'(retry_cnt), 32'd0);
    tick();
    rst_n   = 1'b1;
    n_req   = 0;
    n_retry = 0;
    n_wait  = 0;
    n_iter  = 0;
    while ((state != 3'd7) && (n_iter < 3000)) begin
      tick();
      n_iter++;
      if (gt_req) n_req++;
      if (state == 3'd6) n_retry++;
      if (state == 3'd2) n_wait++;
    end
    check_val("fail_state", 32'(state), 32'd7);
    check_val("fail_timeouts", 32'(n_retry), 32'd8);
    check_val("fail_req_pulses", 32'(n_req), 32'd7);
    check_val("fail_wait_cycles", 32'(n_wait), 32'd512);
    check_val("fail_fatal", 32'(err_fatal), 32'd1);
    check_val("fail_cnt", 32'(retry_cnt), 32'd7);
    check_val("fail_pass", 32'(dec_pass), 32'd1);
    check_val("fail_decrst", 32'(dec_rst), 32'd1);
    repeat (10) tick();
    check_val("fail_sticky", 32'(err_fatal), 32'd1);
    check_val("fail_stays", 32'(state), 32'd7);

    // Asynchronous reset in FAIL.
    rst_n = 1'b0;
    #1;
    check_val("arst_state", 32'(state), 32'd0);
    check_val("arst_pass", 32'(dec_pass), 32'd1);
    check_val("arst_decrst", 32'(dec_rst), 32'd1);
    check_val("arst_req", 32'(gt_req), 32'd0);
    check_val("arst_up", 32'(lane_up), 32'd0);
    check_val("arst_fatal", 32'(err_fatal), 32'd0);
    check_val("arst_cnt", 32'(retry_cnt), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
